// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Brief   : State encoding and channel-slice helper for the skid stage.
// Revision: 1.0  initial release
// ============================================================================
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // 2'd3 is named so the decoder can recover from it explicitly.
  typedef enum logic [1:0] {
    S_EMPTY   = ST_EMPTY,
    S_ONE     = ST_ONE,
    S_FULL    = ST_FULL,
    S_ILLEGAL = 2'd3
  } state_e;

  function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_data_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_data_reg
// Brief   : Load-enabled data register, async active-low clear to zero.
// Revision: 1.0  initial release
// ============================================================================
module pipe_data_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [WIDTH*CHANNELS-1:0] d_i,
  output logic [WIDTH*CHANNELS-1:0] q_o
);

  logic [WIDTH*CHANNELS-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_stage
// Brief   : Valid/ready pipeline register with two-entry skid and flush.
// Revision: 1.0  initial release
// ============================================================================
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*CHANNELS-1:0] out_data
);

  localparam int BITS = WIDTH * CHANNELS;

  state_e          state_q, state_d;
  logic            in_ready_q, out_valid_q;
  logic            in_fire, out_fire;
  logic            main_load, skid_load, main_from_skid;
  logic [BITS-1:0] main_d, main_q, skid_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = S_FULL;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Handshake outputs are flopped from the next state so neither has a
  // combinational path from out_ready or in_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .d_i    (in_data),
    .q_o    (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_skid_stage
// Brief   : Directed and random checks of pipe_skid_stage against a FIFO model.
// Revision: 1.0  initial release
// ============================================================================
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;
  localparam int BITS     = WIDTH * CHANNELS;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [BITS-1:0] mq[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // ch0 = b, ch1 = ~b, ch2 = b ^ 8'h3C
  function automatic logic [BITS-1:0] mk(input logic [7:0] b);
    logic [BITS-1:0] w;
    logic [7:0]      ch [CHANNELS];
    w     = '0;
    ch[0] = b;
    ch[1] = ~b;
    ch[2] = b ^ 8'h3C;
    for (int k = 0; k < CHANNELS; k++) w[chan_lsb(k, WIDTH) +: WIDTH] = ch[k];
    return w;
  endfunction

  task automatic model_check(input string tag);
    chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, ".out_data"}, 64'(out_data), 64'(mq[0]));
  endtask

  // One clock: drive, predict fires from the model, advance the model, sample.
  task automatic step(input string tag, input logic v, input logic [BITS-1:0] d,
                      input logic ordy, input logic fl);
    bit inf, outf;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    inf  = v && (mq.size() < 2);
    outf = ordy && (mq.size() > 0);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf)  mq.push_back(d);
    end
    #1;
    model_check(tag);
  endtask

  initial begin
    logic [BITS-1:0] ones;
    logic [BITS-1:0] xs;
    ones = '1;
    xs   = 'x;

    // Reset held while upstream offers data
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = ones; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.out_data",  64'(out_data),  64'd0);
    rst = 1'b1;
    step("idle", 1'b0, xs, 1'b0, 1'b0);
    step("idle", 1'b0, xs, 1'b0, 1'b0);
    chk("idle.out_data", 64'(out_data), 64'd0);

    // Streaming
    step("strm", 1'b1, mk(8'h11), 1'b1, 1'b0);
    chk("strm.d0", 64'(out_data), 64'(mk(8'h11)));
    step("strm", 1'b1, mk(8'h22), 1'b1, 1'b0);
    chk("strm.d1", 64'(out_data), 64'(mk(8'h22)));
    step("strm", 1'b1, mk(8'h33), 1'b1, 1'b0);
    chk("strm.d2", 64'(out_data), 64'(mk(8'h33)));
    chk("strm.rdy", 64'(in_ready), 64'd1);
    step("strm", 1'b0, xs, 1'b1, 1'b0);
    chk("strm.empty", 64'(out_valid), 64'd0);

    // Stall into the skid and release
    step("skid", 1'b1, mk(8'hA0), 1'b0, 1'b0);
    step("skid", 1'b1, mk(8'hA1), 1'b0, 1'b0);
    chk("skid.rdy_low", 64'(in_ready), 64'd0);
    chk("skid.hold",    64'(out_data), 64'(mk(8'hA0)));
    step("skid", 1'b1, mk(8'hEE), 1'b0, 1'b0);
    chk("skid.hold2",   64'(out_data), 64'(mk(8'hA0)));
    step("skid", 1'b0, xs, 1'b1, 1'b0);
    chk("skid.pop1",    64'(out_data), 64'(mk(8'hA1)));
    chk("skid.rdy_up",  64'(in_ready), 64'd1);
    step("skid", 1'b0, xs, 1'b1, 1'b0);
    chk("skid.drain",   64'(out_valid), 64'd0);

    // Flush while FULL with a word on offer
    step("fl", 1'b1, mk(8'hC0), 1'b0, 1'b0);
    step("fl", 1'b1, mk(8'hC1), 1'b0, 1'b0);
    step("fl", 1'b1, mk(8'hB0), 1'b1, 1'b1);
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.rdy",   64'(in_ready),  64'd1);
    repeat (3) step("fl.after", 1'b0, xs, 1'b1, 1'b0);

    // Async reset between edges while FULL
    step("ar", 1'b1, mk(8'hD0), 1'b0, 1'b0);
    step("ar", 1'b1, mk(8'hD1), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("ar.out_valid", 64'(out_valid), 64'd0);
    chk("ar.in_ready",  64'(in_ready),  64'd1);
    chk("ar.out_data",  64'(out_data),  64'd0);
    mq.delete();
    #1 rst = 1'b1;
    step("ar.after", 1'b0, xs, 1'b1, 1'b0);

    // Random traffic against the FIFO model
    for (int i = 0; i < 10000; i++) begin
      logic            v, r, f;
      logic [BITS-1:0] d;
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 55);
      f = ($urandom_range(0, 199) == 0);
      d = v ? BITS'($urandom) : xs;
      step("rnd", v, d, r, f);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
